key_expansion_128: RTL

Iterative AES-128 key schedule. Accepts one 128-bit cipher key and emits round keys 0 through 10, one per accepted handshake. It sits directly upstream of the round-key XOR stage and drives that stage's `subkey` bus, so the datapath can consume one round key per round.

---
 rtl/key_expansion_128_if.sv | 34 +++
 rtl/key_expansion_128.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/key_expansion_128_if.sv
// Handshake bundle between the AES-128 key schedule and its key source / round-key consumer.
// slave: the key schedule side; master: the driver of keys and consumer of round keys.
interface key_expansion_128_if;
  logic         key_valid;
  logic [127:0] key;
  logic         key_ready;
  logic         subkey_valid;
  logic         subkey_ready;
  logic [127:0] subkey;
  logic [3:0]   subkey_round;
  logic         busy;

  modport slave (
    input  key_valid,
    input  key,
    input  subkey_ready,
    output key_ready,
    output subkey_valid,
    output subkey,
    output subkey_round,
    output busy
  );

  modport master (
    output key_valid,
    output key,
    output subkey_ready,
    input  key_ready,
    input  subkey_valid,
    input  subkey,
    input  subkey_round,
    input  busy
  );
endinterface

// File: rtl/key_expansion_128.sv
// Iterative AES-128 key schedule: one cipher key in, round keys 0..10 out, one per handshake.
// Also holds the shared FIPS-197 S-box (aes_sbox), instantiated four times for SubWord.
// Optional build macro KEY_EXP_RESTART_EN: key input stays ready during an expansion and a new
// key aborts the current expansion (a reload beats a simultaneous round-key handshake).

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Entry 255 (MSB byte) holds S(0x00), so S(x) is found at index ~x.
  localparam logic [255:0][7:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SboxTable[~in_i];
endmodule

module key_expansion_128 (
  input logic                    clk,
  input logic                    rst_n,
  key_expansion_128_if.slave     kx_io
);

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  state_e       state_q, state_d;
  logic [127:0] subkey_q, subkey_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;

  logic         key_ready;
  logic         subkey_valid;
  logic         subkey_hs;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_word, sub_word, temp_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  assign w0 = subkey_q[127:96];
  assign w1 = subkey_q[95:64];
  assign w2 = subkey_q[63:32];
  assign w3 = subkey_q[31:0];

  assign rot_word = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_word[8*i +: 8]),
      .out_o (sub_word[8*i +: 8])
    );
  end

  // Single round step: w3' depends on the whole w0'..w2' chain.
  assign temp_word = sub_word ^ {rcon_q, 24'h000000};
  assign n0        = w0 ^ temp_word;
  assign n1        = w1 ^ n0;
  assign n2        = w2 ^ n1;
  assign n3        = w3 ^ n2;
  assign next_key  = {n0, n1, n2, n3};

  assign subkey_valid = (state_q == StExpand);
`ifdef KEY_EXP_RESTART_EN
  assign key_ready    = 1'b1;
`else
  assign key_ready    = (state_q == StIdle);
`endif
  assign subkey_hs    = subkey_valid && kx_io.subkey_ready;

  assign kx_io.key_ready    = key_ready;
  assign kx_io.subkey_valid = subkey_valid;
  assign kx_io.busy         = subkey_valid;
  assign kx_io.subkey       = subkey_q;
  assign kx_io.subkey_round = round_q;

  // Next-state: load on key acceptance, step on handshake, return to idle after round 10.
  always_comb begin
    state_d  = state_q;
    subkey_d = subkey_q;
    round_d  = round_q;
    rcon_d   = rcon_q;
    unique case (state_q)
      StIdle: begin
        if (kx_io.key_valid) begin
          subkey_d = kx_io.key;
          round_d  = 4'd0;
          rcon_d   = 8'h01;
          state_d  = StExpand;
        end
      end
      StExpand: begin
`ifdef KEY_EXP_RESTART_EN
        if (kx_io.key_valid) begin
          subkey_d = kx_io.key;
          round_d  = 4'd0;
          rcon_d   = 8'h01;
        end else
`endif
        if (subkey_hs) begin
          if (round_q < 4'd10) begin
            subkey_d = next_key;
            round_d  = round_q + 4'd1;
            rcon_d   = xtime(rcon_q);
          end else begin
            // Last key stays on the bus; only valid drops.
            state_d = StIdle;
          end
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      subkey_q <= 128'h0;
      round_q  <= 4'd0;
      rcon_q   <= 8'h01;
    end else begin
      state_q  <= state_d;
      subkey_q <= subkey_d;
      round_q  <= round_d;
      rcon_q   <= rcon_d;
    end
  end

endmodule
